// File: rtl/ws2812_rx_pkg.sv
// Shared WS2812 receiver definitions: timing defaults, counter width and FSM state encoding.
package ws2812_rx_pkg;

  localparam int CNT_W          = 10;
  localparam int WORD_W         = 24;
  localparam int DEF_T_MIN_HIGH = 2;
  localparam int DEF_T_BIT_THRESH = 7;
  localparam int DEF_T_MAX_HIGH = 20;
  localparam int DEF_T_LATCH    = 600;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_FWD  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Saturating increment so long idle lines never wrap back through the latch threshold.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Measures each high pulse on the synchronised line and classifies it on the falling edge
// as glitch (ignored), valid bit (with value) or overlong.
module ws2812_pulse_meas
  import ws2812_rx_pkg::*;
#(
  parameter int T_MIN_HIGH   = DEF_T_MIN_HIGH,
  parameter int T_BIT_THRESH = DEF_T_BIT_THRESH,
  parameter int T_MAX_HIGH   = DEF_T_MAX_HIGH
) (
  input  logic hwclk,
  input  logic reset_n,
  input  logic i_dinS,
  output logic o_bitValid,
  output logic o_bitValue,
  output logic o_overlong
);

  logic             r_dinPrev;
  logic [CNT_W-1:0] r_highCnt;
  logic             w_fall;
  logic             w_tooLong;

  // The rising-edge cycle itself counts as the first high cycle.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      r_dinPrev <= 1'b0;
      r_highCnt <= '0;
    end else begin
      r_dinPrev <= i_dinS;
      if (i_dinS && !r_dinPrev) begin
        r_highCnt <= CNT_W'(1);
      end else if (i_dinS) begin
        r_highCnt <= satInc(r_highCnt);
      end
    end
  end

  assign w_fall     = !i_dinS && r_dinPrev;
  assign w_tooLong  = r_highCnt > CNT_W'(T_MAX_HIGH);
  assign o_overlong = w_fall && w_tooLong;
  assign o_bitValid = w_fall && !w_tooLong && (r_highCnt >= CNT_W'(T_MIN_HIGH));
  assign o_bitValue = r_highCnt >= CNT_W'(T_BIT_THRESH);

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 pixel receiver: absorbs the first 24 bits of a frame, forwards the rest, and
// latches the captured word on the reset gap.
module ws2812_rx
  import ws2812_rx_pkg::*;
#(
  parameter int T_MIN_HIGH   = DEF_T_MIN_HIGH,
  parameter int T_BIT_THRESH = DEF_T_BIT_THRESH,
  parameter int T_MAX_HIGH   = DEF_T_MAX_HIGH,
  parameter int T_LATCH      = DEF_T_LATCH
) (
  input  logic              hwclk,
  input  logic              reset_n,
  input  logic              din,
  output logic              dout,
  output logic [WORD_W-1:0] rgb,
  output logic              rgb_valid,
  output logic              frame_err
);

  logic              r_sync1;
  logic              r_dinS;
  logic [CNT_W-1:0]  r_lowCnt;
  state_t            r_state;
  state_t            w_nextState;
  logic [WORD_W-1:0] r_shift;
  logic [4:0]        r_bitCnt;
  logic              w_bitValid;
  logic              w_bitValue;
  logic              w_overlong;
  logic              w_latch;
  logic              w_startFrame;
  logic              w_shiftEn;
  logic              w_loadRgb;
  logic              w_errStrobe;

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_dinS   <= 1'b0;
      r_lowCnt <= '0;
    end else begin
      r_sync1  <= din;
      r_dinS   <= r_sync1;
      r_lowCnt <= r_dinS ? '0 : satInc(r_lowCnt);
    end
  end

  ws2812_pulse_meas #(
    .T_MIN_HIGH  (T_MIN_HIGH),
    .T_BIT_THRESH(T_BIT_THRESH),
    .T_MAX_HIGH  (T_MAX_HIGH)
  ) u_pulseMeas (
    .hwclk     (hwclk),
    .reset_n   (reset_n),
    .i_dinS    (r_dinS),
    .o_bitValid(w_bitValid),
    .o_bitValue(w_bitValue),
    .o_overlong(w_overlong)
  );

  // Saturation past T_LATCH makes this a single-cycle event per low gap.
  assign w_latch = (r_lowCnt == CNT_W'(T_LATCH));

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_startFrame = 1'b0;
    w_shiftEn    = 1'b0;
    w_loadRgb    = 1'b0;
    w_errStrobe  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_overlong) begin
          w_errStrobe = 1'b1;
          w_nextState = ST_ERR;
        end else if (w_bitValid) begin
          w_startFrame = 1'b1;
          w_nextState  = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_overlong) begin
          w_errStrobe = 1'b1;
          w_nextState = ST_ERR;
        end else if (w_bitValid) begin
          w_shiftEn = 1'b1;
          if (r_bitCnt == 5'(WORD_W - 1)) begin
            w_nextState = ST_FWD;
          end
        end else if (w_latch) begin
          w_errStrobe = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (w_overlong) begin
          w_errStrobe = 1'b1;
          w_nextState = ST_ERR;
        end else if (w_latch) begin
          w_loadRgb   = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (w_latch) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bitCnt  <= '0;
      rgb       <= '0;
      rgb_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_startFrame) begin
        r_shift  <= {{(WORD_W-1){1'b0}}, w_bitValue};
        r_bitCnt <= 5'd1;
      end else if (w_shiftEn) begin
        r_shift  <= {r_shift[WORD_W-2:0], w_bitValue};
        r_bitCnt <= r_bitCnt + 5'd1;
      end
      if (w_loadRgb) begin
        rgb <= r_shift;
      end
      rgb_valid <= w_loadRgb;
      frame_err <= w_errStrobe;
    end
  end

  assign dout = (r_state == ST_FWD) && r_dinS;

endmodule
